// File: rtl/dpu_host_word_bridge.sv
// Host word-op front-end for the layer-0 DPU byte-command port: splits 32-bit writes/reads into
// little-endian byte commands, gathers read bytes, and times runs until done.
module dpu_host_word_bridge #(
  parameter int RSP_TIMEOUT = 255,
  parameter int ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [1:0]        h_op,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [31:0]       h_wdata,
  input  logic [3:0]        h_be,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [31:0]       r_data,
  output logic              r_err,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [1:0]        m_cmd_type,
  output logic [ADDR_W-1:0] m_cmd_addr,
  output logic [7:0]        m_cmd_data,
  input  logic              m_rsp_valid,
  input  logic [7:0]        m_rsp_data,
  input  logic              m_done,
  output logic              busy
);

  localparam int TW = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, W_ISSUE, R_ISSUE, R_WAIT, RUN_ISSUE, RUN_WAIT, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        lane_q, lane_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic              cmd_fire;
  logic [2:0]        first_lane, next_lane;
  logic [31:0]       cyc_inc;

  // Lowest enabled lane at or above 'from'; 4 means none remain.
  function automatic logic [2:0] next_en(input logic [3:0] be, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && be[i]) r = i[2:0];
    end
    return r;
  endfunction

  assign busy     = (state_q != IDLE);
  assign h_ready  = (state_q == IDLE) && !rst;
  assign r_valid  = (state_q == RESP);
  assign r_data   = data_q;
  assign r_err    = err_q;
  assign cmd_fire = m_cmd_valid && m_cmd_ready;

  assign first_lane = next_en(h_be, 3'd0);
  assign next_lane  = next_en(be_q, {1'b0, lane_q} + 3'd1);
  assign cyc_inc    = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

  // Command fields come straight from held state, so they cannot move while stalled.
  always_comb begin
    m_cmd_valid = 1'b0;
    m_cmd_type  = 2'd0;
    m_cmd_addr  = '0;
    m_cmd_data  = 8'd0;
    case (state_q)
      W_ISSUE: begin
        m_cmd_valid = 1'b1;
        m_cmd_type  = 2'd0;
        m_cmd_addr  = addr_q + ADDR_W'(lane_q);
        m_cmd_data  = wdata_q[8*lane_q +: 8];
      end
      R_ISSUE: begin
        m_cmd_valid = 1'b1;
        m_cmd_type  = 2'd2;
        m_cmd_addr  = addr_q + ADDR_W'(lane_q);
      end
      RUN_ISSUE: begin
        m_cmd_valid = 1'b1;
        m_cmd_type  = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    lane_d  = lane_q;
    tmo_d   = tmo_q;
    cyc_d   = cyc_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (h_valid && h_ready) begin
          addr_d  = h_addr;
          wdata_d = h_wdata;
          be_d    = h_be;
          lane_d  = 2'd0;
          data_d  = 32'd0;
          err_d   = 1'b0;
          case (h_op)
            2'd0: begin
              if (h_be != 4'd0) begin
                state_d = W_ISSUE;
                lane_d  = first_lane[1:0];
              end else begin
                state_d = RESP;
              end
            end
            2'd1:    state_d = RUN_ISSUE;
            2'd2:    state_d = R_ISSUE;
            default: begin
              state_d = RESP;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      W_ISSUE: begin
        if (cmd_fire) begin
          if (next_lane[2]) state_d = RESP;
          else              lane_d  = next_lane[1:0];
        end
      end
      R_ISSUE: begin
        if (cmd_fire) begin
          state_d = R_WAIT;
          tmo_d   = '0;
        end
      end
      R_WAIT: begin
        if (m_rsp_valid || tmo_q == TW'(RSP_TIMEOUT - 1)) begin
          if (m_rsp_valid) begin
            data_d[8*lane_q +: 8] = m_rsp_data;
          end else begin
            data_d[8*lane_q +: 8] = 8'hEE;
            err_d                 = 1'b1;
          end
          if (lane_q == 2'd3) begin
            state_d = RESP;
          end else begin
            state_d = R_ISSUE;
            lane_d  = lane_q + 2'd1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RUN_ISSUE: begin
        if (cmd_fire) begin
          state_d = RUN_WAIT;
          cyc_d   = 32'd0;
        end
      end
      RUN_WAIT: begin
        cyc_d = cyc_inc;
        if (m_done) begin
          data_d  = cyc_inc;
          state_d = RESP;
        end
      end
      RESP: begin
        if (r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      lane_q  <= 2'd0;
      tmo_q   <= '0;
      cyc_q   <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dpu_host_word_bridge.sv
// Directed bench for dpu_host_word_bridge: inputs driven and outputs checked just after each falling edge.
module tb_dpu_host_word_bridge;

  localparam int TMO = 255;
  localparam int AW  = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          h_valid, h_ready;
  logic [1:0]    h_op;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_wdata;
  logic [3:0]    h_be;
  logic          r_valid, r_ready;
  logic [31:0]   r_data;
  logic          r_err;
  logic          m_cmd_valid, m_cmd_ready;
  logic [1:0]    m_cmd_type;
  logic [AW-1:0] m_cmd_addr;
  logic [7:0]    m_cmd_data;
  logic          m_rsp_valid;
  logic [7:0]    m_rsp_data;
  logic          m_done;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  dpu_host_word_bridge #(.RSP_TIMEOUT(TMO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .h_valid(h_valid), .h_ready(h_ready), .h_op(h_op), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_be(h_be),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_type(m_cmd_type),
    .m_cmd_addr(m_cmd_addr), .m_cmd_data(m_cmd_data),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_done(m_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one host op for a single cycle; returns at the falling edge after acceptance.
  task automatic host_op(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    h_valid = 1'b1; h_op = op; h_addr = a; h_wdata = wd; h_be = be;
    tick();
    h_valid = 1'b0;
  endtask

  task automatic ack_resp();
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("resp_done", {r_valid, h_ready, busy}, {1'b0, 1'b1, 1'b0});
  endtask

  // One read lane: check the command, let it be accepted, answer two cycles later.
  task automatic read_lane(input string tag, input logic [AW-1:0] a, input logic [7:0] d);
    chk(tag, {m_cmd_valid, m_cmd_type, m_cmd_addr}, {1'b1, 2'd2, a});
    tick();
    tick();
    m_rsp_valid = 1'b1; m_rsp_data = d;
    tick();
    m_rsp_valid = 1'b0; m_rsp_data = 8'h00;
  endtask

  initial begin
    rst = 1'b1; h_valid = 1'b0; h_op = 2'd0; h_addr = '0; h_wdata = 32'd0; h_be = 4'd0;
    r_ready = 1'b0; m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = 8'h00; m_done = 1'b0;
    tick(); tick();
    chk("reset_outs", {h_ready, m_cmd_valid, m_cmd_type, m_cmd_addr, m_cmd_data, r_valid, r_err, busy},
        {1'b0, 1'b0, 2'd0, 24'h0, 8'h00, 1'b0, 1'b0, 1'b0});
    chk("reset_rdata", r_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {h_ready, busy}, {1'b1, 1'b0});

    // Full little-endian write, DPU always ready
    m_cmd_ready = 1'b1;
    host_op(2'd0, 24'h0000F3, 32'h04030201, 4'hF);
    chk("wr_full0", {m_cmd_valid, m_cmd_type, m_cmd_addr, m_cmd_data}, {1'b1, 2'd0, 24'h0000F3, 8'h01});
    tick();
    chk("wr_full1", {m_cmd_valid, m_cmd_addr, m_cmd_data}, {1'b1, 24'h0000F4, 8'h02});
    tick();
    chk("wr_full2", {m_cmd_valid, m_cmd_addr, m_cmd_data}, {1'b1, 24'h0000F5, 8'h03});
    tick();
    chk("wr_full3", {m_cmd_valid, m_cmd_addr, m_cmd_data}, {1'b1, 24'h0000F6, 8'h04});
    tick();
    chk("wr_full_resp", {m_cmd_valid, r_valid, r_err, r_data}, {1'b0, 1'b1, 1'b0, 32'd0});
    ack_resp();

    // Sparse write with stalls: only lanes 0 and 2
    m_cmd_ready = 1'b0;
    host_op(2'd0, 24'h000100, 32'h44332211, 4'b0101);
    chk("wr_sp0", {m_cmd_valid, m_cmd_addr, m_cmd_data}, {1'b1, 24'h000100, 8'h11});
    tick();
    chk("wr_sp0_stall", {m_cmd_valid, m_cmd_addr, m_cmd_data}, {1'b1, 24'h000100, 8'h11});
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    chk("wr_sp2", {m_cmd_valid, m_cmd_addr, m_cmd_data}, {1'b1, 24'h000102, 8'h33});
    tick();
    chk("wr_sp2_stall", {m_cmd_valid, m_cmd_addr, m_cmd_data}, {1'b1, 24'h000102, 8'h33});
    m_cmd_ready = 1'b1;
    tick();
    chk("wr_sp_resp", {m_cmd_valid, r_valid, r_err, r_data}, {1'b0, 1'b1, 1'b0, 32'd0});
    ack_resp();

    // No enabled lanes: immediate response, no command
    host_op(2'd0, 24'h000200, 32'hFFFFFFFF, 4'b0000);
    chk("wr_be0", {m_cmd_valid, r_valid, r_err, r_data}, {1'b0, 1'b1, 1'b0, 32'd0});
    ack_resp();

    // Read wrapping past the top of the address space
    host_op(2'd2, 24'hFFFFFE, 32'd0, 4'd0);
    read_lane("rd_wrap0", 24'hFFFFFE, 8'hAA);
    read_lane("rd_wrap1", 24'hFFFFFF, 8'hBB);
    read_lane("rd_wrap2", 24'h000000, 8'hCC);
    read_lane("rd_wrap3", 24'h000001, 8'hDD);
    chk("rd_wrap_resp", {r_valid, r_err, r_data}, {1'b1, 1'b0, 32'hDDCCBBAA});
    ack_resp();

    // Read with lane 1 never answered
    host_op(2'd2, 24'h000010, 32'd0, 4'd0);
    read_lane("rd_to0", 24'h000010, 8'hAA);
    chk("rd_to1", {m_cmd_valid, m_cmd_type, m_cmd_addr}, {1'b1, 2'd2, 24'h000011});
    tick();
    repeat (TMO - 1) tick();
    chk("rd_to_waiting", {m_cmd_valid, busy}, {1'b0, 1'b1});
    tick();
    read_lane("rd_to2", 24'h000012, 8'hCC);
    read_lane("rd_to3", 24'h000013, 8'hDD);
    chk("rd_to_resp", {r_valid, r_err, r_data}, {1'b1, 1'b1, 32'hDDCCEEAA});
    ack_resp();

    // Run: done sampled on the 100th cycle after acceptance
    host_op(2'd1, 24'h00ABCD, 32'h12345678, 4'hF);
    chk("run_cmd", {m_cmd_valid, m_cmd_type, m_cmd_addr, m_cmd_data}, {1'b1, 2'd1, 24'h0, 8'h00});
    tick();
    repeat (99) tick();
    chk("run_no_early_resp", {r_valid, busy}, {1'b0, 1'b1});
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("run_resp", {r_valid, r_err, r_data}, {1'b1, 1'b0, 32'd100});
    ack_resp();

    // Stray done while idle must not produce a response
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    tick();
    chk("stray_done", {r_valid, busy, h_ready}, {1'b0, 1'b0, 1'b1});

    // Reset in the middle of a write
    host_op(2'd0, 24'h000020, 32'hDEADBEEF, 4'hF);
    tick();
    chk("abort_lane2", {m_cmd_valid, m_cmd_addr}, {1'b1, 24'h000021});
    tick();
    rst = 1'b1;
    tick();
    chk("abort_outs", {m_cmd_valid, r_valid, busy, h_ready}, {1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    tick();
    chk("abort_idle", {h_ready, m_cmd_valid}, {1'b1, 1'b0});

    // Illegal op, then error flag clears on the next op
    host_op(2'd3, 24'h000030, 32'h0, 4'hF);
    chk("illegal_resp", {m_cmd_valid, r_valid, r_err, r_data}, {1'b0, 1'b1, 1'b1, 32'd0});
    ack_resp();
    host_op(2'd0, 24'h000040, 32'h0, 4'h0);
    chk("err_cleared", {r_valid, r_err}, {1'b1, 1'b0});
    ack_resp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
